// File: rtl/alu_iter_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode map, sequencer state type and opcode classification
//                helper shared by the iterative ALU and its sub-blocks.
//                ALU_ITER_DIVIDE_EN adds ops 20/21 to the iterative set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_ADC  = 8'd1;
  localparam logic [7:0] OP_SUB  = 8'd2;
  localparam logic [7:0] OP_SBC  = 8'd3;
  localparam logic [7:0] OP_OR   = 8'd4;
  localparam logic [7:0] OP_AND  = 8'd5;
  localparam logic [7:0] OP_NOT  = 8'd6;
  localparam logic [7:0] OP_XOR  = 8'd7;
  localparam logic [7:0] OP_CMP  = 8'd8;
  localparam logic [7:0] OP_SHL  = 8'd12;
  localparam logic [7:0] OP_SHR  = 8'd13;
  localparam logic [7:0] OP_MUL  = 8'd16;
  localparam logic [7:0] OP_MULL = 8'd17;
  localparam logic [7:0] OP_MULH = 8'd18;
  localparam logic [7:0] OP_DIVU = 8'd20;
  localparam logic [7:0] OP_REMU = 8'd21;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } alu_state_t;

  // True for opcodes that run on the multi-cycle shift datapath.
  function automatic logic is_iterative(input logic [7:0] op);
    logic r;
    r = (op == OP_MUL) || (op == OP_MULL) || (op == OP_MULH);
`ifdef ALU_ITER_DIVIDE_EN
    r = r || (op == OP_DIVU) || (op == OP_REMU);
`endif
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_if.sv
// ============================================================================
//  Module      : alu_iter_if
//  Description : Request/result bundle between the sequencer (master) and
//                the iterative ALU (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [7:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] c;
  logic             carry_out;
  logic             is_zero;
  logic             is_negative;

  modport master (
    output start, op, a, b, carry_in,
    input  busy, valid, c, carry_out, is_zero, is_negative
  );

  modport slave (
    input  start, op, a, b, carry_in,
    output busy, valid, c, carry_out, is_zero, is_negative
  );
endinterface

`default_nettype wire

// File: rtl/alu_comb.sv
// ============================================================================
//  Module      : alu_comb
//  Description : Single-cycle ALU operations (add/sub/logic/cmp/shift).
//                Returns {carry, result}; unknown opcodes give all zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [7:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH:0]   o_res
);

  // Opcode decode; the bit above the MSB carries carry/borrow.
  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD: o_res = {1'b0, i_a} + {1'b0, i_b};
      OP_ADC: o_res = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_carry};
      OP_SUB: o_res = {1'b0, i_a} - {1'b0, i_b};
      OP_SBC: o_res = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_carry};
      OP_OR:  o_res = {1'b0, i_a | i_b};
      OP_AND: o_res = {1'b0, i_a & i_b};
      OP_NOT: o_res = {1'b0, ~i_a};
      OP_XOR: o_res = {1'b0, i_a ^ i_b};
      OP_CMP: begin
        if (i_a < i_b)       o_res = {1'b1, {WIDTH{1'b1}}};
        else if (i_a == i_b) o_res = '0;
        else                 o_res = {{WIDTH{1'b0}}, 1'b1};
      end
      OP_SHL: o_res = {i_a[WIDTH-1], i_a[WIDTH-2:0], 1'b0};
      OP_SHR: o_res = {i_a[0], 1'b0, i_a[WIDTH-1:1]};
      default: o_res = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_iter.sv
// ============================================================================
//  Module      : alu_iter
//  Description : Multi-cycle ALU. Single-cycle ops via alu_comb; multiply
//                (and divide with ALU_ITER_DIVIDE_EN) as a one-bit-per-cycle
//                shift-add / restoring-subtract loop on a 2*WIDTH register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_iter_if.slave  bus
);

  localparam int c_cnt_w = $clog2(WIDTH) + 1;
  localparam int c_half  = WIDTH / 2;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   c_low_mask = {{c_half{1'b0}}, {c_half{1'b1}}};

  alu_state_t           r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [7:0]           r_op;
  logic [WIDTH-1:0]     r_opnd;

  logic [WIDTH-1:0]     r_c;
  logic                 r_carry, r_zero, r_neg, r_valid;

  logic [WIDTH:0]       w_comb;
  logic                 w_div_zero, w_iter_start, w_wr, w_cout;
  logic [WIDTH-1:0]     w_res;
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_mul_step, w_acc_step;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_op    (bus.op),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .i_carry (bus.carry_in),
    .o_res   (w_comb)
  );

  assign w_iter_start = bus.start && (r_state == IDLE) && is_iterative(bus.op) && !w_div_zero;

  // Multiply step: multiplier sits in the low half and shifts out LSB-first.
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_step = r_acc[0] ? {w_madd, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

`ifdef ALU_ITER_DIVIDE_EN
  logic [WIDTH+1:0]   w_dsub;
  logic [2*WIDTH-1:0] w_div_step;
  logic               w_is_div;
  // Divide step: upper half is the partial remainder, lower half the dividend
  // shifting out MSB-first while quotient bits shift in.
  assign w_is_div   = (r_op == OP_DIVU) || (r_op == OP_REMU);
  assign w_dsub     = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_opnd};
  assign w_div_step = w_dsub[WIDTH+1] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_acc_step = w_is_div ? w_div_step : w_mul_step;
  assign w_div_zero = ((bus.op == OP_DIVU) || (bus.op == OP_REMU)) && (bus.b == '0);
`else
  assign w_acc_step = w_mul_step;
  assign w_div_zero = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and result selection.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_res       = w_comb[WIDTH-1:0];
    w_cout      = w_comb[WIDTH];
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_iter_start) begin
            w_state_nxt = ITER;
          end else begin
            w_wr = 1'b1;
            if (w_div_zero) begin
              w_res  = (bus.op == OP_DIVU) ? {WIDTH{1'b1}} : bus.a;
              w_cout = 1'b1;
            end
          end
        end
      end
      ITER: begin
        if (r_cnt == c_last_cnt) begin
          w_state_nxt = IDLE;
          w_wr        = 1'b1;
          w_cout      = 1'b0;
          case (r_op)
            OP_MULH: w_res = w_acc_step[2*WIDTH-1:WIDTH];
`ifdef ALU_ITER_DIVIDE_EN
            OP_REMU: w_res = w_acc_step[2*WIDTH-1:WIDTH];
`endif
            default: w_res = w_acc_step[WIDTH-1:0];
          endcase
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Iterative datapath: operand capture at accept, one step per ITER cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_op   <= '0;
      r_opnd <= '0;
    end else if (w_iter_start) begin
      r_cnt <= '0;
      r_op  <= bus.op;
      if (bus.op == OP_MUL) begin
        r_opnd <= bus.a & c_low_mask;
        r_acc  <= {{WIDTH{1'b0}}, bus.b & c_low_mask};
      end
`ifdef ALU_ITER_DIVIDE_EN
      else if ((bus.op == OP_DIVU) || (bus.op == OP_REMU)) begin
        r_opnd <= bus.b;
        r_acc  <= {{WIDTH{1'b0}}, bus.a};
      end
`endif
      else begin
        r_opnd <= bus.a;
        r_acc  <= {{WIDTH{1'b0}}, bus.b};
      end
    end else if (r_state == ITER) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Result and flag registers, written only on a valid cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_c     <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
      r_neg   <= 1'b0;
    end else begin
      r_valid <= w_wr;
      if (w_wr) begin
        r_c     <= w_res;
        r_carry <= w_cout;
        r_zero  <= (w_res == '0);
        r_neg   <= w_res[WIDTH-1];
      end
    end
  end

  assign bus.busy        = (r_state == ITER);
  assign bus.valid       = r_valid;
  assign bus.c           = r_c;
  assign bus.carry_out   = r_carry;
  assign bus.is_zero     = r_zero;
  assign bus.is_negative = r_neg;

endmodule

`default_nettype wire
